// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared tristate datapath bus: one-hot grant,
// one-cycle turnaround between owners, and a hold timer that preempts long transfers.
module bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDXW     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] owner,
    output logic            busy,
    output logic            preempt
);

    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr, rr_ptr_d;
    logic [HCW-1:0]  hold_cnt, hold_cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDXW-1:0] owner_d;
    logic            busy_d;
    logic            preempt_d;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic            others_waiting;

    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return IDXW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // First requesting master at or after rr_ptr, wrapping.
    always_comb begin
        logic [IDXW-1:0] cand;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_add(rr_ptr, i);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign others_waiting = |(req & ~onehot(owner));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr;
        hold_cnt_d = hold_cnt;
        gnt_d      = gnt;
        owner_d    = owner;
        busy_d     = busy;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (pick_valid) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    gnt_d      = onehot(pick_idx);
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_d  = TURN;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = wrap_add(owner, 1);
                end else if (hold_cnt == HOLD_SAT && others_waiting && !lock[owner]) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = 1'b1;
                    rr_ptr_d  = wrap_add(owner, 1);
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_ptr_d;
            hold_cnt <= hold_cnt_d;
            gnt      <= gnt_d;
            owner    <= owner_d;
            busy     <= busy_d;
            preempt  <= preempt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expectations queued per step, popped and
// compared one cycle later on the falling edge.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic       preempt;
        logic [1:0] owner;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_owner = 2'd0;

    bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .IDXW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle of inputs just after a falling edge; check the result one edge later.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] g, input logic p);
        exp_t e;
        exp_t got;
        req  = r;
        lock = l;
        if (g != 4'b0000) exp_owner = idx_of(g);
        e.gnt = g; e.busy = |g; e.preempt = p; e.owner = exp_owner;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty got=0 exp=1", tag);
        end
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk({tag, ".gnt"},     gnt,            got.gnt);
            chk({tag, ".busy"},    {3'b0, busy},    {3'b0, got.busy});
            chk({tag, ".preempt"}, {3'b0, preempt}, {3'b0, got.preempt});
            chk({tag, ".owner"},   {2'b0, owner},   {2'b0, got.owner});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_owner = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst.gnt",     gnt,                4'b0000);
        chk("rst.owner",   {2'b0, owner},      4'b0000);
        chk("rst.busy",    {3'b0, busy},       4'b0000);
        chk("rst.preempt", {3'b0, preempt},    4'b0000);
        rst_n = 1'b1;

        // 1: single grant then normal release
        step("t1.grant", 4'b0001, 4'b0000, 4'b0001, 1'b0);
        step("t1.turn",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        step("t1.idle",  4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 2: all request, hold timer rotates ownership
        do_reset();
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 8; c++)
                step($sformatf("t2.m%0d.c%0d", m, c), 4'b1111, 4'b0000, 4'(1 << m), 1'b0);
            step($sformatf("t2.turn%0d", m), 4'b1111, 4'b0000, 4'b0000, 1'b1);
        end
        step("t2.wrap", 4'b1111, 4'b0000, 4'b0001, 1'b0);

        // 3: lock holds owner past saturation; non-owner lock is ignored
        do_reset();
        for (int c = 0; c < 24; c++)
            step($sformatf("t3.lock%0d", c), 4'b0011, 4'b0001, 4'b0001, 1'b0);
        step("t3.unlock", 4'b0011, 4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 8; c++)
            step($sformatf("t3.m1.%0d", c), 4'b0011, 4'b0001, 4'b0010, 1'b0);
        step("t3.nolock", 4'b0011, 4'b0001, 4'b0000, 1'b1);
        step("t3.back0",  4'b0011, 4'b0001, 4'b0001, 1'b0);
        step("t3.rel",    4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 4: owner drops req while another waits
        do_reset();
        step("t4.c1", 4'b0001, 4'b0000, 4'b0001, 1'b0);
        step("t4.c2", 4'b0001, 4'b0000, 4'b0001, 1'b0);
        step("t4.c3", 4'b0101, 4'b0000, 4'b0001, 1'b0);
        step("t4.c4", 4'b0101, 4'b0000, 4'b0001, 1'b0);
        step("t4.turn", 4'b0100, 4'b0000, 4'b0000, 1'b0);
        step("t4.m2",   4'b0100, 4'b0000, 4'b0100, 1'b0);
        step("t4.rel",  4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 5: sole requester never preempted; saturated counter fires on new req
        do_reset();
        for (int c = 0; c < 20; c++)
            step($sformatf("t5.sole%0d", c), 4'b0010, 4'b0000, 4'b0010, 1'b0);
        step("t5.preempt", 4'b1010, 4'b0000, 4'b0000, 1'b1);
        step("t5.m3",      4'b1010, 4'b0000, 4'b1000, 1'b0);
        step("t5.rel",     4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 6: asynchronous reset mid-grant, restart from master 0
        do_reset();
        step("t6.g2a", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        step("t6.g2b", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.async.gnt",   gnt,             4'b0000);
        chk("t6.async.busy",  {3'b0, busy},    4'b0000);
        chk("t6.async.owner", {2'b0, owner},   4'b0000);
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_owner = 2'd0;
        step("t6.first", 4'b1111, 4'b0000, 4'b0001, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb.leftover got=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
